// File: rtl/divide_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU.
// Produces one quotient bit per cycle and stalls EX until the result is ready.
module divide_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             ex_flush,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic             start;
    logic             load;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_work;

    assign start = (op_div | op_divu) & ~ex_flush;

    // DIV wins over DIVU, so only op_div selects signed magnitudes
    assign mag_a = (op_div & dividend[WIDTH-1]) ? -dividend : dividend;
    assign mag_b = (op_div & divisor[WIDTH-1]) ? -divisor : divisor;

    // work_q shifts dividend bits out at the top and quotient bits in at the bottom
    assign shifted   = {part_q, work_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign ge        = shifted[WIDTH] | ~diff[WIDTH];
    assign step_rem  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_work = {work_q[WIDTH-2:0], ge};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        part_d      = part_q;
        work_d      = work_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    load    = 1'b1;
                end
            end
            BUSY: begin
                if (ex_flush) begin
                    state_d = IDLE;
                end else begin
                    part_d  = step_rem;
                    work_d  = step_work;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        quotient_d  = q_neg_q ? -step_work : step_work;
                        remainder_d = r_neg_q ? -step_rem : step_rem;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = BUSY;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            count_d = '0;
            part_d  = '0;
            work_d  = mag_a;
            dvs_d   = mag_b;
            q_neg_d = op_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = op_div & dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            part_q      <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            part_q      <= part_d;
            work_q      <= work_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = ~reset & ~ex_flush & (state_q == DONE);
    assign stall     = ~reset & (((state_q == IDLE) & start) | (state_q == BUSY));

endmodule

// File: tb/tb_divide_unit.sv
// Directed and random checks of divide_unit against a scoreboard of
// expected quotient/remainder pairs.
module tb_divide_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_div;
    logic        op_divu;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ex_flush;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic        stall;

    int vectors = 0;
    int errs    = 0;
    logic [63:0] sb[$];

    divide_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .op_div   (op_div),
        .op_divu  (op_divu),
        .dividend (dividend),
        .divisor  (divisor),
        .ex_flush (ex_flush),
        .quotient (quotient),
        .remainder(remainder),
        .done     (done),
        .stall    (stall)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {quotient, remainder}
    function automatic logic [63:0] model(bit sgn, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (!sgn) begin
            if (b == 32'd0) return {32'hFFFFFFFF, a};
            return {a / b, a % b};
        end
        if (b == 32'd0) return {(a[31] ? 32'h1 : 32'hFFFFFFFF), a};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
        sa  = a;
        sb_ = b;
        q   = sa / sb_;
        r   = sa % sb_;
        return {q, r};
    endfunction

    task automatic start_op(bit sgn, logic [31:0] a, logic [31:0] b);
        op_div   = sgn;
        op_divu  = ~sgn;
        dividend = a;
        divisor  = b;
        sb.push_back(model(sgn, a, b));
    endtask

    // Called in the first BUSY cycle; returns in the DONE cycle
    task automatic wait_done(string tag);
        int k;
        logic [63:0] exp;
        op_div  = 1'b0;
        op_divu = 1'b0;
        k = 1;
        while (!done && k <= 40) begin
            chk({tag, "_stall_busy"}, 64'(stall), 64'd1);
            tick();
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk({tag, "_quotient"}, 64'(quotient), 64'(exp[63:32]));
            chk({tag, "_remainder"}, 64'(remainder), 64'(exp[31:0]));
        end else begin
            chk({tag, "_scoreboard_empty"}, 64'd1, 64'(sb.size()));
        end
    endtask

    task automatic run_div(string tag, bit sgn, logic [31:0] a, logic [31:0] b);
        start_op(sgn, a, b);
        #1;
        chk({tag, "_stall_start"}, 64'(stall), 64'd1);
        tick();
        wait_done(tag);
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic pick(output bit sgn, output logic [31:0] a, output logic [31:0] b);
        sgn = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = $urandom;
        if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
    endtask

    initial begin
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        bit          seen;

        reset    = 1'b1;
        op_div   = 1'b0;
        op_divu  = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        ex_flush = 1'b0;
        tick();
        tick();
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        op_divu = 1'b0;
        reset   = 1'b0;
        tick();
        chk("idle_stall", 64'(stall), 64'd0);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
        run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_div("div_m9_0", 1'b1, 32'hFFFFFFF7, 32'd0);
        run_div("div_both", 1'b1, 32'd7, 32'hFFFFFFFE);

        // Flush mid-divide must leave the previous result in place
        run_div("divu_100_7b", 1'b0, 32'd100, 32'd7);
        start_op(1'b0, 32'd50, 32'd3);
        tick();
        op_divu = 1'b0;
        repeat (9) tick();
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        void'(sb.pop_back());
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_stall", 64'(stall), 64'd0);
        chk("flush_quotient", 64'(quotient), 64'd14);
        chk("flush_remainder", 64'(remainder), 64'd2);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk("flush_no_done", 64'(seen), 64'd0);

        // Reset mid-divide abandons it
        start_op(1'b0, 32'd1000, 32'd3);
        tick();
        op_divu = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        chk("midrst_quotient", 64'(quotient), 64'd0);
        chk("midrst_remainder", 64'(remainder), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        reset = 1'b0;
        void'(sb.pop_back());
        tick();
        chk("post_rst_stall", 64'(stall), 64'd0);
        run_div("divu_9_4", 1'b0, 32'd9, 32'd4);

        // Back-to-back: a new op is presented in each DONE cycle
        pick(sgn, a, b);
        start_op(sgn, a, b);
        tick();
        for (int i = 0; i < 12; i++) begin
            wait_done("b2b");
            if (i < 11) begin
                pick(sgn, a, b);
                start_op(sgn, a, b);
                #1;
                chk("b2b_stall_in_done", 64'(stall), 64'd0);
            end
            tick();
        end
        op_div  = 1'b0;
        op_divu = 1'b0;
        #1;
        chk("b2b_end_done", 64'(done), 64'd0);
        chk("b2b_end_stall", 64'(stall), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/divide_unit.md
DIVIDE_UNIT -- requirements
Module: divide_unit

Interface
REQ-001 The block SHALL expose one parameter: WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clock, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous, active-high, and the block is clocked by clock.
REQ-004 The block SHALL have port op_div, input, 1 bit, start a signed divide (DIV).
REQ-005 The block SHALL have port op_divu, input, 1 bit, start an unsigned divide (DIVU).
REQ-006 The block SHALL have port dividend, input, 32 bits, the forwarded rs operand.
REQ-007 The block SHALL have port divisor, input, 32 bits, the forwarded rt operand.
REQ-008 The block SHALL have port ex_flush, input, 1 bit, aborts the divide in progress.
REQ-009 The block SHALL have port quotient, output, 32 bits, destined for LO.
REQ-010 The block SHALL have port remainder, output, 32 bits, destined for HI.
REQ-011 The block SHALL have port done, output, 1 bit, one-cycle pulse signalling that the results are valid, used as the HILO write strobe.
REQ-012 The block SHALL have port stall, output, 1 bit, holds the EX stage while a divide is in progress.

Function
REQ-013 The block SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 start SHALL be defined as (op_div | op_divu) & ~ex_flush; if op_div and op_divu are both high, the signed divide (DIV) SHALL win.
REQ-015 In IDLE with start active, the block SHALL latch the operand magnitudes, the quotient sign (dividend[31]^divisor[31]), the remainder sign (dividend[31]) and a signed flag, then go to BUSY with iteration count 0.
REQ-016 For an unsigned divide, the magnitudes SHALL be the raw operands and no sign correction SHALL be applied.
REQ-017 BUSY SHALL perform one restoring shift-subtract quotient bit per clock, MSB first, using a 33-bit partial remainder, for exactly 32 cycles.
REQ-018 After the 32nd iteration, the block SHALL apply sign correction (two's-complement negate of each result whose sign bit is set), register quotient/remainder, and enter DONE.
REQ-019 Latency: if start is sampled in cycle n, BUSY SHALL occupy cycles n+1..n+32 and done SHALL be high in cycle n+33 only.
REQ-020 stall SHALL be combinational: high in IDLE when start is active, and high throughout BUSY.
REQ-021 stall SHALL be low in DONE and in IDLE without start.
REQ-022 In DONE, start active SHALL accept a new divide (go to BUSY); otherwise the block SHALL return to IDLE.
REQ-023 quotient and remainder SHALL hold their last values until the next completed divide; they SHALL never change mid-operation.
REQ-024 op_div and op_divu SHALL be ignored while in BUSY.
REQ-025 ex_flush high in BUSY or DONE SHALL force IDLE at the next edge, suppress done, and leave quotient/remainder unchanged; ex_flush has priority over start.
REQ-026 Divisor zero SHALL raise no exception and keep the full latency, with raw magnitude results quotient=32'hFFFFFFFF and remainder=|dividend| before sign correction.
REQ-027 For divide-by-zero, DIVU SHALL yield quotient=32'hFFFFFFFF and remainder=dividend.
REQ-028 Signed 32'h80000000 / 32'hFFFFFFFF SHALL wrap to quotient=32'h80000000, remainder=0, with no overflow indication.
REQ-029 Every signed result SHALL satisfy dividend = quotient*divisor + remainder (mod 2^32), with |remainder| < |divisor| and remainder taking the sign of the dividend, for divisor != 0.

Reset
REQ-030 While reset is high, the FSM SHALL be in IDLE, the iteration count 0, and quotient=0, remainder=0, done=0, stall=0.
REQ-031 Reset SHALL take priority over ex_flush and start.
REQ-032 Reset asserted mid-BUSY SHALL abandon the divide with no done pulse.

Verification
REQ-033 Bench SHALL cover: op_divu, 100 / 7 -> stall high for cycles n..n+32, done in cycle n+33, quotient=14, remainder=2.
REQ-034 Bench SHALL cover: op_div, 32'hFFFFFFF9 (-7) / 2 -> quotient=32'hFFFFFFFD (-3), remainder=32'hFFFFFFFF (-1).
REQ-035 Bench SHALL cover: op_div, 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0; op_divu, 5 / 0 -> quotient=32'hFFFFFFFF, remainder=5.
REQ-036 Bench SHALL cover: divide 100/7 completes, then 50/3 starts and ex_flush pulses at BUSY iteration 10 -> no done, IDLE next cycle, outputs remain 14/2.
REQ-037 Bench SHALL cover: reset asserted at BUSY iteration 20 -> next cycle IDLE, all outputs 0, no done; a following 9/4 divide completes normally with quotient=2, remainder=1.
REQ-038 Bench SHALL cover back-to-back operation: start held during DONE -> the second divide is accepted with no idle gap, done pulses 33 cycles apart, and random signed/unsigned operands match a reference model.
